// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit between register-file reads and write-back.
// Define MULDIV_FAST_MUL_EN to replace the 32-cycle shift-add multiplier with a single-cycle one;
// division stays iterative in both builds and results are identical.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic            wr_en,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    state_t            state, state_next;
    logic [1:0]        op_q;
    logic [4:0]        count;
    logic [2*XLEN-1:0] acc, acc_step;
    logic [XLEN-1:0]   opnd;
    logic              neg_main, neg_rem;

    logic              is_div, a_signed, b_signed, neg_a, neg_b;
    logic              div_zero, div_ovf, special, fast_mul;
    logic [XLEN-1:0]   mag_a, mag_b, special_result, fast_result;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quot, rem, final_result;

    // Decode the incoming instruction: signedness, operand magnitudes and the divide special cases
    always_comb begin
        is_div   = funct3[2];
        a_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        b_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
        neg_a    = a_signed & op_a[XLEN-1];
        neg_b    = b_signed & op_b[XLEN-1];
        mag_a    = neg_a ? -op_a : op_a;
        mag_b    = neg_b ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && ~funct3[0] && (op_a == MIN_INT) && (op_b == ALL_ONES);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_result = funct3[1] ? op_a : ALL_ONES;
        end else begin
            special_result = funct3[1] ? '0 : MIN_INT;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

    // Single-cycle multiply: sign-extending to 2*XLEN gives the same low bits as a 33x33 signed product
    always_comb begin
        fast_a      = {{XLEN{a_signed & op_a[XLEN-1]}}, op_a};
        fast_b      = {{XLEN{b_signed & op_b[XLEN-1]}}, op_b};
        fast_prod   = fast_a * fast_b;
        fast_result = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        fast_mul    = 1'b1;
    end
`else
    // Iterative build: multiplies always go through the MUL state
    always_comb begin
        fast_result = '0;
        fast_mul    = 1'b0;
    end
`endif

    // One iteration of shift-add multiply or restoring divide, plus the sign-corrected final result
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (state == DIV) begin
            acc_step = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end
        prod_signed = neg_main ? -acc_step : acc_step;
        quot        = neg_main ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem         = neg_rem ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        if (state == DIV) begin
            final_result = op_q[1] ? rem : quot;
        end else begin
            final_result = (op_q == 2'b00) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic and the handshake outputs toward the core and register file
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (special || (fast_mul && !is_div)) begin
                        state_next = DONE;
                    end else begin
                        state_next = is_div ? DIV : MUL;
                    end
                end
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (count == 5'd31) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        wr_en = done;
        stall = ((state == IDLE) && start) || busy;
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: latch operands on accept, iterate, register the result on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            rd_out   <= '0;
            count    <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= funct3[1:0];
                        rd_out   <= rd_in;
                        count    <= '0;
                        neg_main <= neg_a ^ neg_b;
                        neg_rem  <= neg_a;
                        opnd     <= is_div ? mag_b : mag_a;
                        acc      <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        if (special) begin
                            result <= special_result;
                        end else if (fast_mul && !is_div) begin
                            result <= fast_result;
                        end
                    end
                end
                MUL, DIV: begin
                    acc   <= acc_step;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        result <= final_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit.
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        stall, busy, done, wr_en;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_done_cyc = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .wr_en  (wr_en),
        .rd_out (rd_out),
        .result (result)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Free-running cycle count used to time done pulses
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issue one instruction from a negedge and follow it to its write-back beat.
    // Returns positioned at the negedge of the IDLE cycle after done.
    task automatic apply_stimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] rd,
                                  input logic [31:0] expected, input int exp_lat, input bit hold);
        int  lat = 0;
        int  stall_cnt = 0;
        bit  seen = 1'b0;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        #1;
        if (stall) stall_cnt++;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen          = 1'b1;
                lat           = k;
                last_done_cyc = cyc;
                check_output({tag, " result"}, result, expected);
                check_output({tag, " rd_out"}, rd_out, rd);
                check_output({tag, " wr_en"}, wr_en, 1);
                check_output({tag, " stall at done"}, stall, 0);
            end else if (stall) begin
                stall_cnt++;
            end
            if (hold && !done) begin
                op_a = $urandom;
                op_b = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_output({tag, " latency"}, lat, exp_lat);
        check_output({tag, " stall cycles"}, stall_cnt, exp_lat);
        @(negedge clk);
        check_output({tag, " done single pulse"}, done, 0);
    endtask

    initial begin
        int first_done;
        int done_cnt;

        repeat (2) @(negedge clk);
        check_output("reset busy", busy, 0);
        check_output("reset done", done, 0);
        check_output("reset wr_en", wr_en, 0);
        check_output("reset stall", stall, 0);
        check_output("reset rd_out", rd_out, 0);
        check_output("reset result", result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiply family with 0xFFFF_FFFF x 2
        apply_stimulus("MUL -1*2",    3'b000, 32'hFFFF_FFFF, 32'd2, 5'd1, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
        apply_stimulus("MULH -1*2",   3'b001, 32'hFFFF_FFFF, 32'd2, 5'd2, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
        apply_stimulus("MULHSU -1*2", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
        apply_stimulus("MULHU",       3'b011, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'h0000_0001, MUL_LAT, 1'b0);
        // Sign handling at the extremes
        apply_stimulus("MUL -3*5",    3'b000, 32'hFFFF_FFFD, 32'd5, 5'd5, 32'hFFFF_FFF1, MUL_LAT, 1'b0);
        apply_stimulus("MULH min*min",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, MUL_LAT, 1'b0);
        apply_stimulus("MULHSU min*2^31", 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'hC000_0000, MUL_LAT, 1'b0);
        apply_stimulus("MULHU 2^31*2^31", 3'b011, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h4000_0000, MUL_LAT, 1'b0);

        // Divide family
        apply_stimulus("DIV -7/2",  3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, DIV_LAT, 1'b0);
        apply_stimulus("REM -7/2",  3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
        apply_stimulus("DIVU 7/2",  3'b101, 32'd7, 32'd2, 5'd12, 32'd3, DIV_LAT, 1'b0);
        apply_stimulus("REMU 7/2",  3'b111, 32'd7, 32'd2, 5'd13, 32'd1, DIV_LAT, 1'b0);
        apply_stimulus("DIV -7/-2", 3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd14, 32'd3, DIV_LAT, 1'b0);
        apply_stimulus("REM -7/-2", 3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
        apply_stimulus("DIVU max/1", 3'b101, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'hFFFF_FFFF, DIV_LAT, 1'b0);

        // Special cases finish one cycle after accept
        apply_stimulus("DIVU 5/0",     3'b101, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, 1, 1'b0);
        apply_stimulus("REMU 5/0",     3'b111, 32'd5, 32'd0, 5'd17, 32'd5, 1, 1'b0);
        apply_stimulus("DIV min/-1",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1, 1'b0);
        apply_stimulus("REM min/-1",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0, 1, 1'b0);

        // start held with operands changing underneath the operation
        apply_stimulus("DIV 1000/-7 held", 3'b100, 32'd1000, 32'hFFFF_FFF9, 5'd20, 32'hFFFF_FF72, DIV_LAT, 1'b1);
        apply_stimulus("REM 1000/-7 held", 3'b110, 32'd1000, 32'hFFFF_FFF9, 5'd21, 32'd6, DIV_LAT, 1'b1);

        // Back-to-back multiplies
        apply_stimulus("MUL 6*7 first",  3'b000, 32'd6, 32'd7, 5'd22, 32'd42, MUL_LAT, 1'b0);
        first_done = last_done_cyc;
        apply_stimulus("MUL 6*7 second", 3'b000, 32'd6, 32'd7, 5'd23, 32'd42, MUL_LAT, 1'b0);
        check_output("back-to-back interval", last_done_cyc - first_done, MUL_LAT + 1);

        // Reset ten cycles into a divide
        start  = 1'b1;
        funct3 = 3'b100;
        op_a   = 32'd100;
        op_b   = 32'd7;
        rd_in  = 5'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("abort busy", busy, 0);
        check_output("abort done", done, 0);
        check_output("abort result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_output("abort no done", done_cnt, 0);
        apply_stimulus("MUL 3*4 after abort", 3'b000, 32'd3, 32'd4, 5'd24, 32'd12, MUL_LAT, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the register file read ports and upstream of its write port. It latches the two source operands (register read data 1/2) and the destination index when an M-extension instruction issues. It computes the result over multiple cycles while stalling the single-cycle core, then presents a one-cycle write-back beat (result, rd, write enable) for the register file write port.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock, shared with the register file.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  decoded M-extension instruction present this cycle.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value, from register read data 1.
- op_b  in  XLEN  rs2 value, from register read data 2.
- rd_in  in  5  destination register index.
- stall  out  1  hold PC/instruction; combinational.
- busy  out  1  an operation is in flight (state MUL or DIV).
- done  out  1  one-cycle write-back beat.
- wr_en  out  1  equals done; drives the register-file write enable through the core's write-back mux.
- rd_out  out  5  latched rd_in; valid when done.
- result  out  XLEN  write-back data; valid when done, held until the next accept.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE with start=1 accepts the instruction:
  - latch funct3, rd_in and the operand magnitudes; record the sign-correction flags;
  - iteration counter := 0;
  - funct3[2]=0 → MUL; funct3[2]=1 → DIV.
- Special cases are detected at accept and go directly IDLE→DONE:
  - divide by zero: DIV/DIVU result 0xFFFF_FFFF; REM/REMU result = op_a;
  - signed overflow (DIV/REM with op_a=0x8000_0000, op_b=0xFFFF_FFFF): DIV result 0x8000_0000, REM result 0.
- MUL: shift-add on unsigned magnitudes, one multiplier bit per cycle, 64-bit product, 32 cycles.
  - Signed operands (MULH: both; MULHSU: op_a only) are converted to magnitude and the product is negated at the end if the signs differ.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- DIV: restoring division on magnitudes (DIVU/REMU use raw operands), one quotient bit per cycle, 32 cycles.
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
- Counter reaching 31 → DONE; the final result is registered on that edge.
- DONE lasts exactly one cycle with done=wr_en=1, then returns to IDLE unconditionally.
- start in MUL, DIV or DONE is ignored; the core holds the instruction via stall and re-presents it only if the decode changes.
- stall = (state==IDLE & start) | busy.
  - In DONE, stall=0, so the core retires the instruction and advances on the same edge the write occurs.
- rd_out=0 still produces done/wr_en; the register file discards x0 writes.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, busy=0, done=0, wr_en=0, stall=0 unless start, rd_out=0, result=0, counter=0.
- Latency, accept edge at cycle N:
  - normal MUL/DIV: busy high N+1..N+32, done at N+33;
  - special case: done at N+1.
- Back-to-back: the next start can be accepted in the IDLE cycle after DONE; minimum issue interval is 34 cycles.
- Reset asserted mid-operation aborts immediately: no done, no write.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MUL-class ops use a single-cycle 33×33 signed multiplier and go IDLE→DONE, with done at N+1;
  - the MUL state is unused;
  - DIV timing is unchanged.
- MULDIV_FAST_MUL_EN undefined: iterative multiplier with 33-cycle latency as above.
- Results are identical in both builds.

## Test plan
- Reset mid-DIV (assert rst_n=0 at cycle N+10) → busy=0, done never pulses, result=0, a following MUL 3×4 completes normally with result=12.
- MUL op_a=0xFFFF_FFFF, op_b=2; then MULH, MULHSU, MULHU with the same operands:
  - MUL result=0xFFFF_FFFE;
  - MULH result=0xFFFF_FFFF;
  - MULHSU result=0xFFFF_FFFF;
  - MULHU result=0x0000_0001;
  - each done at N+33 (N+1 with MULDIV_FAST_MUL_EN).
- DIV -7/2 → result=0xFFFF_FFFD (−3); REM -7/2 → 0xFFFF_FFFF (−1); DIVU 7/2 → 3; REMU 7/2 → 1; done at N+33, rd_out=rd_in.
- DIVU 5/0 → result 0xFFFF_FFFF, REMU 5/0 → result 5, DIV 0x8000_0000/−1 → 0x8000_0000, REM same operands → 0; each done at N+1.
- start held high through the whole DIV with changing operands → the latched result is unaffected; stall=1 for N..N+32 and 0 at N+33; exactly one done pulse.
- Two back-to-back MUL 6×7 instructions → two done pulses 34 cycles apart, both with result=42.
